// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: register IDs and the basic data types used by the
// fetch, decode and write-back stages.
package y86_pkg;

  localparam int unsigned WORD_W   = 64;
  localparam int unsigned NUM_REGS = 15;

  typedef logic [3:0]        reg_id_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam reg_id_t RRAX  = 4'h0;
  localparam reg_id_t RRCX  = 4'h1;
  localparam reg_id_t RRDX  = 4'h2;
  localparam reg_id_t RRBX  = 4'h3;
  localparam reg_id_t RRSP  = 4'h4;
  localparam reg_id_t RRBP  = 4'h5;
  localparam reg_id_t RRSI  = 4'h6;
  localparam reg_id_t RRDI  = 4'h7;
  localparam reg_id_t RR8   = 4'h8;
  localparam reg_id_t RR9   = 4'h9;
  localparam reg_id_t RR10  = 4'hA;
  localparam reg_id_t RR11  = 4'hB;
  localparam reg_id_t RR12  = 4'hC;
  localparam reg_id_t RR13  = 4'hD;
  localparam reg_id_t RR14  = 4'hE;
  localparam reg_id_t RNONE = 4'hF;

  // True when the ID names a real architectural register.
  function automatic logic is_reg(input reg_id_t id);
    return id != RNONE;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the Y86-64 register file.
// Returns 0 for RNONE and while reset is asserted. With REGFILE_BYPASS_EN defined,
// a read that hits a same-cycle write returns the write data (valM over valE).
module regfile_read_port
  import y86_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  reg_id_t           src_i,
  input  logic [DATA_W-1:0] regs_i [NUM_REGS],
  input  reg_id_t           dst_e_i,
  input  logic [DATA_W-1:0] val_e_i,
  input  reg_id_t           dst_m_i,
  input  logic [DATA_W-1:0] val_m_i,
  output logic [DATA_W-1:0] rdata_o
);

`ifndef REGFILE_BYPASS_EN
  // Write-port inputs only matter to the bypass build.
  logic unused_bypass;
  assign unused_bypass = ^{wr_en_i, dst_e_i, val_e_i, dst_m_i, val_m_i};
`endif

  // Select stored value, optionally overridden by an in-flight write.
  always_comb begin
    rdata_o = '0;
    if (rst_n_i && is_reg(src_i)) begin
      rdata_o = regs_i[src_i];
`ifdef REGFILE_BYPASS_EN
      if (wr_en_i) begin
        if (src_i == dst_m_i) begin
          rdata_o = val_m_i;
        end else if (src_i == dst_e_i) begin
          rdata_o = val_e_i;
        end
      end
`endif
    end
  end

endmodule

// File: rtl/reg_file.sv
// Y86-64 SEQ register file: 15 x DATA_W registers, two write ports (E, M) and two
// combinational read ports (A, B), plus a committed-write counter.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module reg_file
  import y86_pkg::*;
#(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] RSP_RESET = '0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  reg_id_t           dst_e_i,
  input  logic [DATA_W-1:0] val_e_i,
  input  reg_id_t           dst_m_i,
  input  logic [DATA_W-1:0] val_m_i,
  input  reg_id_t           src_a_i,
  input  reg_id_t           src_b_i,
  output logic [DATA_W-1:0] val_a_o,
  output logic [DATA_W-1:0] val_b_o,
  output logic [31:0]       wr_cnt_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [31:0]       wr_cnt_q, wr_cnt_d;

  logic we_e, we_m, we_e_eff;

  // Decode port activity; on a collision the E write is dropped so M wins.
  always_comb begin
    we_m     = wr_en_i && is_reg(dst_m_i);
    we_e     = wr_en_i && is_reg(dst_e_i);
    we_e_eff = we_e && !(we_m && (dst_e_i == dst_m_i));
  end

  // Next register contents and write count.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we_m && (dst_m_i == reg_id_t'(i))) begin
        regs_d[i] = val_m_i;
      end else if (we_e_eff && (dst_e_i == reg_id_t'(i))) begin
        regs_d[i] = val_e_i;
      end
    end
    wr_cnt_d = wr_cnt_q + 32'(we_e_eff) + 32'(we_m);
  end

  // State update with synchronous reset; write ports are ignored during reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (reg_id_t'(i) == RRSP) ? RSP_RESET : '0;
      end
      wr_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign wr_cnt_o = wr_cnt_q;

  regfile_read_port #(
    .DATA_W (DATA_W)
  ) u_port_a (
    .rst_n_i (rst_n_i),
    .wr_en_i (wr_en_i),
    .src_i   (src_a_i),
    .regs_i  (regs_q),
    .dst_e_i (dst_e_i),
    .val_e_i (val_e_i),
    .dst_m_i (dst_m_i),
    .val_m_i (val_m_i),
    .rdata_o (val_a_o)
  );

  regfile_read_port #(
    .DATA_W (DATA_W)
  ) u_port_b (
    .rst_n_i (rst_n_i),
    .wr_en_i (wr_en_i),
    .src_i   (src_b_i),
    .regs_i  (regs_q),
    .dst_e_i (dst_e_i),
    .val_e_i (val_e_i),
    .dst_m_i (dst_m_i),
    .val_m_i (val_m_i),
    .rdata_o (val_b_o)
  );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected read/count values each
// cycle, a negedge monitor pops and compares. Honours REGFILE_BYPASS_EN.
module tb_reg_file;
  import y86_pkg::*;

  localparam int unsigned DW  = 64;
  localparam logic [63:0] RSP = 64'h200;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [3:0]    dst_e, dst_m, src_a, src_b;
  logic [63:0]   val_e, val_m, val_a, val_b;
  logic [31:0]   wr_cnt;

  reg_file #(
    .DATA_W    (DW),
    .RSP_RESET (RSP)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .wr_en_i  (wr_en),
    .dst_e_i  (dst_e),
    .val_e_i  (val_e),
    .dst_m_i  (dst_m),
    .val_m_i  (val_m),
    .src_a_i  (src_a),
    .src_b_i  (src_b),
    .val_a_o  (val_a),
    .val_b_o  (val_b),
    .wr_cnt_o (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [31:0] cnt;
    bit          chk_cnt;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [63:0] model [15];
  logic [31:0] mcnt;
  bit          known = 1'b0;
  int          checks = 0;
  int          failures = 0;

  // Architectural view of a read under the current inputs.
  function automatic logic [63:0] exp_read(input logic [3:0] src);
    if (!rst_n || src == 4'hF) return 64'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && src == dst_m) return val_m;
    if (wr_en && src == dst_e) return val_e;
`endif
    return model[src];
  endfunction

  task automatic cycle(input string tag, input logic rst, input logic we,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm,
                       input logic [3:0] sa, input logic [3:0] sb);
    exp_t e;
    int   n;
    rst_n = rst; wr_en = we; dst_e = de; val_e = ve; dst_m = dm; val_m = vm;
    src_a = sa; src_b = sb;
    e.a = exp_read(sa);
    e.b = exp_read(sb);
    e.cnt = mcnt;
    e.chk_cnt = known;
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 15; i++) model[i] = (i == 4) ? RSP : 64'h0;
      mcnt  = 0;
      known = 1'b1;
    end else if (we) begin
      n = 0;
      if (de != 4'hF) begin model[de] = ve; n++; end
      if (dm != 4'hF) begin model[dm] = vm; if (dm != de) n++; end
      mcnt = mcnt + 32'(n);
    end
    #1;
  endtask

  // Monitor: read ports are combinational, so every cycle presents a result.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (val_a !== mon_e.a) begin
        failures++;
        $display("FAIL %s valA: got %h expected %h", mon_e.tag, val_a, mon_e.a);
      end
      checks++;
      if (val_b !== mon_e.b) begin
        failures++;
        $display("FAIL %s valB: got %h expected %h", mon_e.tag, val_b, mon_e.b);
      end
      if (mon_e.chk_cnt) begin
        checks++;
        if (wr_cnt !== mon_e.cnt) begin
          failures++;
          $display("FAIL %s wr_cnt: got %0d expected %0d", mon_e.tag, wr_cnt, mon_e.cnt);
        end
      end
    end
  end

  initial begin
    logic       r, w;
    logic [3:0] de, dm, sa, sb;
    int         wait_cnt;
    mcnt = 0;
    rst_n = 1'b0; wr_en = 1'b0; dst_e = 4'hF; dst_m = 4'hF; val_e = '0; val_m = '0;
    src_a = 4'h0; src_b = 4'h0;
    @(posedge clk); #1;

    // Directed sequence
    cycle("reset0",    0, 1, 4'h2, 64'h11,        4'h3, 64'h22,  4'h4, 4'h0);
    cycle("reset1",    0, 1, 4'h2, 64'h11,        4'h3, 64'h22,  4'h4, 4'h0);
    cycle("rsp_rd",    1, 0, 4'hF, 64'h0,         4'hF, 64'h0,   4'h4, 4'h0);
    cycle("wr_e",      1, 1, 4'h2, 64'hDEAD_BEEF, 4'hF, 64'h0,   4'h2, 4'h0);
    cycle("rd_r2",     1, 0, 4'hF, 64'h0,         4'hF, 64'h0,   4'h2, 4'h4);
    cycle("dual_wr",   1, 1, 4'h4, 64'h1F8,       4'h3, 64'h55,  4'h4, 4'h3);
    cycle("dual_rd",   1, 0, 4'hF, 64'h0,         4'hF, 64'h0,   4'h4, 4'h3);
    cycle("collide",   1, 1, 4'h4, 64'h208,       4'h4, 64'hABC, 4'h4, 4'h4);
    cycle("coll_rd",   1, 0, 4'hF, 64'h0,         4'hF, 64'h0,   4'h4, 4'h2);
    cycle("wren_off",  1, 0, 4'h1, 64'h7,         4'hF, 64'h0,   4'h1, 4'hF);
    cycle("off_rd",    1, 0, 4'hF, 64'h0,         4'hF, 64'h0,   4'h1, 4'hF);
    cycle("rnone_wr",  1, 1, 4'hF, 64'h123,       4'hF, 64'h0,   4'h1, 4'hF);
    cycle("same_cyc",  1, 1, 4'h5, 64'h9,         4'hF, 64'h0,   4'h5, 4'h5);
    cycle("same_rd",   1, 0, 4'hF, 64'h0,         4'hF, 64'h0,   4'h5, 4'h2);
    cycle("m_only",    1, 1, 4'hF, 64'h0,         4'h6, 64'h66,  4'h6, 4'h6);
    cycle("mid_rst",   0, 1, 4'h6, 64'h77,        4'h7, 64'h88,  4'h6, 4'h7);
    cycle("post_rst",  1, 0, 4'hF, 64'h0,         4'hF, 64'h0,   4'h6, 4'h4);
    cycle("post_rst2", 1, 0, 4'hF, 64'h0,         4'hF, 64'h0,   4'h2, 4'h5);

    // Randomized traffic, biased toward collisions and RNONE
    for (int k = 0; k < 600; k++) begin
      r  = ($urandom_range(63, 0) != 0);
      w  = ($urandom_range(3, 0) != 0);
      de = 4'($urandom_range(15, 0));
      dm = ($urandom_range(7, 0) == 0) ? de : 4'($urandom_range(15, 0));
      sa = ($urandom_range(3, 0) == 0) ? de : 4'($urandom_range(15, 0));
      sb = ($urandom_range(3, 0) == 0) ? dm : 4'($urandom_range(15, 0));
      cycle("random", r, w, de, {$urandom, $urandom}, dm, {$urandom, $urandom}, sa, sb);
    end

    // Drain the scoreboard with a bounded wait
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk); #1;
      wait_cnt++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
